// File: rtl/mem_copy_dma.sv
// Block COPY / FILL engine that drives the single-port data memory while busy.
// Memory strobes decode from the registered state only, so start never reaches the memory port.
//
//  state  | meaning
//  IDLE   | waiting for start, memory port released
//  RD     | COPY read of mem[src_ptr] into the word buffer
//  WR     | write of buffer (COPY) or fill value (FILL) to mem[dst_ptr]
//  DONE   | one-cycle completion pulse, then back to IDLE
module mem_copy_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic [DATA_W-1:0] fill_value_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_en_o,
  output logic              mem_read_en_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              aborted_q, aborted_d;
  logic [LEN_W-1:0]  words_inc;

  assign words_inc = words_q + LEN_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      buf_q     <= '0;
      words_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
      words_q   <= words_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    words_d   = words_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          src_d     = src_addr_i;
          dst_d     = dst_addr_i;
          len_d     = length_i;
          fill_d    = fill_value_i;
          words_d   = '0;
          aborted_d = 1'b0;
          if (length_i == '0)  state_d = S_DONE;
          else if (mode_i)     state_d = S_WR;
          else                 state_d = S_RD;
        end
      end
      S_RD: begin
        buf_d = mem_read_data_i;
        src_d = src_q + ADDR_W'(1);
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        dst_d   = dst_q + ADDR_W'(1);
        words_d = words_inc;
        // The write issued this cycle always commits, even when it is cut short by abort.
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (words_inc == len_q) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_write_en_o   = 1'b0;
    mem_read_en_o    = 1'b0;
    case (state_q)
      S_RD: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = src_q;
      end
      S_WR: begin
        mem_write_en_o   = 1'b1;
        mem_addr_o       = dst_q;
        mem_write_data_o = mode_q ? fill_q : buf_q;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign aborted_o    = aborted_q;
  assign words_done_o = words_q;

  a_rd_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == S_RD) |-> !$isunknown(mem_read_data_i));
  a_wr_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == S_WR) |-> !$isunknown(mem_write_data_o));

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: fixed vector table, randomized transfers, abort and reset sequences.
module tb_mem_copy_dma;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic [15:0] src_addr, dst_addr, length, fill_value;
  logic        busy, done, aborted;
  logic [15:0] words_done, mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int checks = 0;
  int errors = 0;

  logic        we_s;
  logic [15:0] wa_s, wd_s;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr];

  mem_copy_dma dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .length_i(length),
    .fill_value_i(fill_value), .abort_i(abort), .busy_o(busy), .done_o(done),
    .aborted_o(aborted), .words_done_o(words_done), .mem_addr_o(mem_addr),
    .mem_write_data_o(mem_write_data), .mem_write_en_o(mem_write_en),
    .mem_read_en_o(mem_read_en), .mem_read_data_i(mem_read_data)
  );

  typedef struct {
    bit          mode;
    logic [15:0] src, dst, len, fill;
    int          ab_k;
    bit          ab_rd;
    int          exp_cyc;
    int          exp_words;
    bit          exp_ab;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory commits a write at the posedge that ends the write cycle; outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    if (we_s) mem[wa_s] = wd_s;
    @(negedge clk);
    we_s = mem_write_en;
    wa_s = mem_addr;
    wd_s = mem_write_data;
  endtask

  task automatic init_mem();
    logic [15:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
  endtask

  function automatic vec_t mk_rand();
    vec_t v;
    v.mode  = 1'($urandom_range(0, 1));
    v.src   = 16'($urandom);
    v.dst   = ($urandom_range(0, 2) == 0) ? 16'(v.src + 16'($urandom_range(0, 10)) - 16'd5)
                                          : 16'($urandom);
    v.len   = 16'($urandom_range(0, 20));
    v.fill  = 16'($urandom);
    v.ab_k  = 0;
    v.ab_rd = 1'b0;
    if (v.len != 0 && $urandom_range(0, 3) == 0) begin
      v.ab_k  = $urandom_range(1, int'(v.len));
      v.ab_rd = !v.mode && ($urandom_range(0, 1) == 1);
    end
    if (v.ab_k == 0) begin
      v.exp_words = int'(v.len);
      v.exp_cyc   = (v.len == 0) ? 1 : (v.mode ? int'(v.len) + 1 : 2 * int'(v.len) + 1);
      v.exp_ab    = 1'b0;
    end else if (v.ab_rd) begin
      v.exp_words = v.ab_k - 1;
      v.exp_cyc   = 2 * v.ab_k;
      v.exp_ab    = 1'b1;
    end else begin
      v.exp_words = v.ab_k;
      v.exp_cyc   = v.mode ? v.ab_k + 1 : 2 * v.ab_k + 1;
      v.exp_ab    = 1'b1;
    end
    return v;
  endfunction

  task automatic run(input vec_t v, input bit poke, input string tag);
    int cyc, rcnt, wcnt, dones, done_cyc, viol, nr, bad, mism;
    logic [15:0] rq[$];
    logic [15:0] wq[$];
    logic [15:0] a;
    rcnt = 0; wcnt = 0; dones = 0; done_cyc = 0; viol = 0;
    start = 1'b1; mode = v.mode; src_addr = v.src; dst_addr = v.dst;
    length = v.len; fill_value = v.fill; abort = 1'b0;
    step();
    start = 1'b0;
    // Scramble the launch inputs: the transfer must use the values latched at start.
    mode = ~v.mode; src_addr = 16'($urandom); dst_addr = 16'($urandom);
    length = 16'($urandom); fill_value = 16'($urandom);
    chk({tag, " aborted_clr"}, {31'd0, aborted}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    cyc = 1;
    while (cyc <= 2 * int'(v.len) + 8) begin
      abort = 1'b0;
      start = 1'b0;
      if (mem_read_en && mem_write_en) viol++;
      if (!mem_read_en && !mem_write_en && (mem_addr != 0 || mem_write_data != 0)) viol++;
      if (mem_read_en) begin
        rq.push_back(mem_addr);
        rcnt++;
        if (v.ab_k > 0 && v.ab_rd && rcnt == v.ab_k) abort = 1'b1;
      end
      if (mem_write_en) begin
        wq.push_back(mem_addr);
        wcnt++;
        if (v.ab_k > 0 && !v.ab_rd && wcnt == v.ab_k) abort = 1'b1;
      end
      if (poke && cyc == 2) start = 1'b1;
      if (done) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && !busy) break;
      step();
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
    chk({tag, " done_cycle"}, done_cyc, v.exp_cyc);
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " words_done"}, {16'd0, words_done}, v.exp_words);
    chk({tag, " aborted"}, {31'd0, aborted}, {31'd0, v.exp_ab});
    chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " strobe_rules"}, viol, 0);
    nr = v.mode ? 0 : (v.ab_rd ? v.ab_k : v.exp_words);
    bad = 0;
    foreach (rq[i]) if (i >= nr || rq[i] !== 16'(v.src + 16'(i))) bad++;
    chk({tag, " rd_seq"}, bad + ((rq.size() == nr) ? 0 : 1000), 0);
    bad = 0;
    foreach (wq[i]) if (i >= v.exp_words || wq[i] !== 16'(v.dst + 16'(i))) bad++;
    chk({tag, " wr_seq"}, bad + ((wq.size() == v.exp_words) ? 0 : 1000), 0);
    for (int i = 0; i < v.exp_words; i++) begin
      a = 16'(v.dst + 16'(i));
      ref_mem[a] = v.mode ? v.fill : ref_mem[16'(v.src + 16'(i))];
    end
    mism = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk({tag, " mem_image"}, mism, 0);
  endtask

  vec_t vt[11];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    we_s = 1'b0; wa_s = '0; wd_s = '0;
    vt[0]  = '{1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0000, 0, 1'b0, 9, 4, 1'b0};
    vt[1]  = '{1'b1, 16'h0000, 16'h0100, 16'd3, 16'hBEEF, 0, 1'b0, 4, 3, 1'b0};
    vt[2]  = '{1'b0, 16'h0500, 16'h0600, 16'd0, 16'h0000, 0, 1'b0, 1, 0, 1'b0};
    vt[3]  = '{1'b1, 16'h0500, 16'h0600, 16'd0, 16'h7777, 0, 1'b0, 1, 0, 1'b0};
    vt[4]  = '{1'b0, 16'hFFFE, 16'h0020, 16'd3, 16'h0000, 0, 1'b0, 7, 3, 1'b0};
    vt[5]  = '{1'b0, 16'h0700, 16'h0800, 16'd8, 16'h0000, 3, 1'b0, 7, 3, 1'b1};
    vt[6]  = '{1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h1234, 0, 1'b0, 5, 4, 1'b0};
    vt[7]  = '{1'b0, 16'h0200, 16'h0201, 16'd4, 16'h0000, 0, 1'b0, 9, 4, 1'b0};
    vt[8]  = '{1'b0, 16'h0301, 16'h0300, 16'd4, 16'h0000, 0, 1'b0, 9, 4, 1'b0};
    vt[9]  = '{1'b0, 16'h0900, 16'h0A00, 16'd5, 16'h0000, 2, 1'b1, 4, 1, 1'b1};
    vt[10] = '{1'b1, 16'h0000, 16'h0B00, 16'd6, 16'hC3C3, 2, 1'b0, 3, 2, 1'b1};

    init_mem();
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + i]     = 16'h00A1 + 16'(i);
      ref_mem[16'h0010 + i] = 16'h00A1 + 16'(i);
    end
    step();
    chk("reset_outputs", {busy, done, aborted, mem_write_en, mem_read_en, words_done, mem_addr | mem_write_data}, 37'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run(vt[i], (i % 2 == 1) && vt[i].len >= 2, $sformatf("vec%0d", i));
      if (vt[i].exp_ab) begin
        abort = 1'b1;
        step();
        step();
        abort = 1'b0;
        chk($sformatf("vec%0d aborted_sticky", i), {31'd0, aborted}, 32'd1);
        chk($sformatf("vec%0d idle_abort_busy", i), {31'd0, busy}, 32'd0);
      end
    end

    // FILL len=5 with a rejected start while busy, then reset during the third write.
    start = 1'b1; mode = 1'b1; dst_addr = 16'h0300; length = 16'd5; fill_value = 16'h5A5A;
    src_addr = 16'h0000;
    step();
    mode = 1'b0; src_addr = 16'h0010; dst_addr = 16'h0900; length = 16'd2;
    step();
    start = 1'b0;
    step();
    chk("rst_seq third_write_addr", {15'd0, mem_write_en, mem_addr}, {16'd1, 16'h0302});
    #2 rst_n = 1'b0;
    #1;
    we_s = 1'b0;
    chk("rst_seq outputs_zero", {busy, done, aborted, mem_write_en, mem_read_en, words_done, mem_addr | mem_write_data}, 37'd0);
    chk("rst_seq word0", {16'd0, mem[16'h0300]}, 32'h5A5A);
    chk("rst_seq word1", {16'd0, mem[16'h0301]}, 32'h5A5A);
    chk("rst_seq no_word3", {16'd0, mem[16'h0303]}, {16'd0, ref_mem[16'h0303]});
    chk("rst_seq ignored_start", {16'd0, mem[16'h0900]}, {16'd0, ref_mem[16'h0900]});
    step();
    rst_n = 1'b1;
    init_mem();
    step();

    for (int n = 0; n < 24; n++) begin
      rv = mk_rand();
      run(rv, (n % 3 == 0) && rv.len >= 2, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
